serial_subtractor: RTL and testbench

Bit-serial WIDTH-bit two's-complement subtractor computing diff = a − b, one bit per clock, LSB first, through a single full-subtractor cell and a registered borrow. It is the inverse-operation counterpart of the team's ripple-carry adder datapath. It trades latency for area and is driven by a start/busy/done handshake. It sits beside the adder as the subtraction unit of the small arithmetic datapath.

---
 rtl/serial_subtractor.sv | 116 +++++++++++
 tb/tb_serial_subtractor.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial two's-complement subtractor: diff = a - b (mod 2^WIDTH).
//   One bit is processed per clock, LSB first, through a single full-subtractor
//   cell with a registered borrow. A start/busy/done handshake frames each op.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   request; only honoured in IDLE or DONE
//   a, b       in   minuend / subtrahend, latched on the accepting edge
//   busy       out  high while bits are being processed
//   done       out  one-cycle pulse when a new result is presented
//   diff       out  a - b modulo 2^WIDTH (holds last result)
//   borrow_out out  final borrow, 1 iff a < b unsigned
//   overflow   out  signed overflow of a - b
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    // Holds the WIDTH-1 bits already produced; the last bit is merged in on
    // the final edge, so the outputs never see a partial result.
    logic [WIDTH-2:0] res;
    logic             a_msb;
    logic             b_msb;
    logic             br;
    logic [CW-1:0]    count;

    logic             d;
    logic             br_next;
    logic [WIDTH-1:0] res_next;
    logic             accept;

    // Full-subtractor cell: returns {borrow_next, difference_bit}.
    function automatic logic [1:0] full_sub(input logic ai, input logic bi, input logic bin);
        logic dd;
        logic bo;
        dd = ai ^ bi ^ bin;
        bo = (~ai & bi) | (~(ai ^ bi) & bin);
        return {bo, dd};
    endfunction

    always_comb begin
        {br_next, d} = full_sub(a_sh[0], b_sh[0], br);
        res_next     = {d, res};
        accept       = start && ((state == IDLE) || (state == DONE));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
            a_sh       <= '0;
            b_sh       <= '0;
            res        <= '0;
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            br         <= 1'b0;
            count      <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                // Accepting from DONE gives back-to-back operation with no gap.
                a_sh  <= a;
                b_sh  <= b;
                a_msb <= a[WIDTH-1];
                b_msb <= b[WIDTH-1];
                res   <= '0;
                br    <= 1'b0;
                count <= '0;
                busy  <= 1'b1;
                state <= RUN;
            end else if (state == RUN) begin
                a_sh  <= a_sh >> 1;
                b_sh  <= b_sh >> 1;
                res   <= res_next[WIDTH-1:1];
                br    <= br_next;
                count <= count + 1'b1;
                if (count == LAST) begin
                    diff       <= res_next;
                    borrow_out <= br_next;
                    // d is the result MSB on this edge.
                    overflow   <= (a_msb != b_msb) && (d != a_msb);
                    busy       <= 1'b0;
                    done       <= 1'b1;
                    state      <= DONE;
                end
            end else if (state == DONE) begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Directed and random checks of serial_subtractor at WIDTH=4 and WIDTH=8.
module tb_serial_subtractor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start4;
    logic [3:0] a4, b4;
    logic       busy4, done4, bo4, ov4;
    logic [3:0] diff4;

    logic       start8;
    logic [7:0] a8, b8;
    logic       busy8, done8, bo8, ov8;
    logic [7:0] diff8;

    int total = 0;
    int bad   = 0;
    logic [3:0] last4;
    logic [7:0] last8;

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .diff(diff4),
        .borrow_out(bo4), .overflow(ov4)
    );

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8),
        .borrow_out(bo8), .overflow(ov8)
    );

    // Launch one WIDTH=4 op, scramble the inputs after acceptance, and wait for done.
    // lat = edges from the accepting edge to the edge that raised done.
    task automatic run4(input logic [3:0] a, input logic [3:0] b,
                        output logic [3:0] d, output logic bo, output logic ov,
                        output int lat);
        @(negedge clk);
        a4 = a; b4 = b; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0; a4 = ~a; b4 = ~b;
        total++;
        if (busy4 !== 1'b1) begin bad++; $display("FAIL run4_busy_on: got %b want 1", busy4); end
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done4 === 1'b1) begin lat = i; break; end
            total++;
            if (busy4 !== 1'b1 || diff4 !== last4) begin
                bad++;
                $display("FAIL run4_hold: busy=%b diff=%b want busy=1 diff=%b", busy4, diff4, last4);
            end
        end
        if (lat == 0) begin
            total++; bad++;
            $display("FAIL run4_timeout: no done within 20 cycles");
        end else begin
            total++;
            if (busy4 !== 1'b0) begin bad++; $display("FAIL run4_busy_off: got %b want 0", busy4); end
        end
        d = diff4; bo = bo4; ov = ov4;
        last4 = a - b;
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] d, output logic bo, output logic ov,
                        output int lat);
        @(negedge clk);
        a8 = a; b8 = b; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; a8 = ~a; b8 = ~b;
        lat = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (done8 === 1'b1) begin lat = i; break; end
            total++;
            if (busy8 !== 1'b1 || diff8 !== last8) begin
                bad++;
                $display("FAIL run8_hold: busy=%b diff=%h want busy=1 diff=%h", busy8, diff8, last8);
            end
        end
        if (lat == 0) begin
            total++; bad++;
            $display("FAIL run8_timeout: no done within 30 cycles");
        end
        d = diff8; bo = bo8; ov = ov8;
        last8 = a - b;
    endtask

    task automatic test_reset();
        rst = 1'b1; start4 = 1'b0; start8 = 1'b0;
        a4 = '0; b4 = '0; a8 = '0; b8 = '0;
        repeat (3) @(negedge clk);
        total++;
        if ({busy4, done4, diff4, bo4, ov4} !== 8'b0) begin
            bad++;
            $display("FAIL reset4: busy=%b done=%b diff=%b bo=%b ov=%b want all 0", busy4, done4, diff4, bo4, ov4);
        end
        total++;
        if ({busy8, done8, diff8, bo8, ov8} !== 12'b0) begin
            bad++;
            $display("FAIL reset8: busy=%b done=%b diff=%h bo=%b ov=%b want all 0", busy8, done8, diff8, bo8, ov8);
        end
        rst = 1'b0;
        last4 = '0; last8 = '0;
        @(negedge clk);
        total++;
        if (busy4 !== 1'b0 || done4 !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: busy=%b done=%b want 0 0", busy4, done4);
        end
    endtask

    // Table of directed WIDTH=4 vectors: a, b, diff, borrow, overflow.
    task automatic test_directed();
        logic [3:0] va [6] = '{4'b0111, 4'b0011, 4'b0000, 4'b1000, 4'b0111, 4'b1111};
        logic [3:0] vb [6] = '{4'b0011, 4'b0101, 4'b0000, 4'b0001, 4'b1111, 4'b1111};
        logic [3:0] vd [6] = '{4'b0100, 4'b1110, 4'b0000, 4'b0111, 4'b1000, 4'b0000};
        logic       vbo[6] = '{1'b0,    1'b1,    1'b0,    1'b0,    1'b1,    1'b0};
        logic       vov[6] = '{1'b0,    1'b0,    1'b0,    1'b1,    1'b1,    1'b0};
        logic [3:0] d;
        logic bo, ov;
        int lat;
        for (int i = 0; i < 6; i++) begin
            run4(va[i], vb[i], d, bo, ov, lat);
            total++;
            if (lat !== 4) begin bad++; $display("FAIL latency[%0d]: got %0d want 4", i, lat); end
            total++;
            if (d !== vd[i] || bo !== vbo[i] || ov !== vov[i]) begin
                bad++;
                $display("FAIL directed[%0d]: diff=%b bo=%b ov=%b want diff=%b bo=%b ov=%b",
                         i, d, bo, ov, vd[i], vbo[i], vov[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        @(negedge clk);
        a4 = 4'd5; b4 = 4'd2; start4 = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n = 0;
            for (int i = 1; i <= 20; i++) begin
                @(negedge clk);
                if (done4 === 1'b1) begin n = i; break; end
            end
            total++;
            if (n != 4) begin bad++; $display("FAIL b2b_latency[%0d]: got %0d want 4", k, n); end
            total++;
            if (diff4 !== 4'b0011 || bo4 !== 1'b0 || ov4 !== 1'b0) begin
                bad++;
                $display("FAIL b2b_result[%0d]: diff=%b bo=%b ov=%b want 0011 0 0", k, diff4, bo4, ov4);
            end
            if (k == 2) start4 = 1'b0;
            @(negedge clk);
            if (k < 2) begin
                total++;
                if (busy4 !== 1'b1 || done4 !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_restart[%0d]: busy=%b done=%b want 1 0", k, busy4, done4);
                end
            end
        end
        total++;
        if (busy4 !== 1'b0 || done4 !== 1'b0) begin
            bad++;
            $display("FAIL b2b_stop: busy=%b done=%b want 0 0", busy4, done4);
        end
        last4 = 4'b0011;
    endtask

    task automatic test_ignore_start();
        int n;
        @(negedge clk);
        a4 = 4'b0110; b4 = 4'b0001; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        start4 = 1'b1; a4 = 4'b1111; b4 = 4'b0000;
        @(negedge clk);
        start4 = 1'b0;
        n = 0;
        for (int i = 3; i <= 20; i++) begin
            @(negedge clk);
            if (done4 === 1'b1) begin n = i; break; end
        end
        total++;
        if (n != 4) begin bad++; $display("FAIL ignore_latency: got %0d want 4", n); end
        total++;
        if (diff4 !== 4'b0101 || bo4 !== 1'b0 || ov4 !== 1'b0) begin
            bad++;
            $display("FAIL ignore_result: diff=%b bo=%b ov=%b want 0101 0 0", diff4, bo4, ov4);
        end
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (done4 === 1'b1 || busy4 === 1'b1) n++;
        end
        total++;
        if (n != 0) begin bad++; $display("FAIL ignore_no_restart: got %0d active cycles want 0", n); end
        last4 = 4'b0101;
    endtask

    task automatic test_reset_midop();
        int n;
        logic [3:0] d;
        logic bo, ov;
        int lat;
        @(negedge clk);
        a4 = 4'b1010; b4 = 4'b0001; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({busy4, done4, diff4, bo4, ov4} !== 8'b0) begin
            bad++;
            $display("FAIL midop_reset: busy=%b done=%b diff=%b bo=%b ov=%b want all 0", busy4, done4, diff4, bo4, ov4);
        end
        last4 = '0; last8 = '0;
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (done4 === 1'b1) n++;
        end
        total++;
        if (n != 0) begin bad++; $display("FAIL midop_no_done: got %0d pulses want 0", n); end
        run4(4'b1010, 4'b0001, d, bo, ov, lat);
        total++;
        if (lat !== 4 || d !== 4'b1001 || bo !== 1'b0 || ov !== 1'b0) begin
            bad++;
            $display("FAIL midop_fresh: lat=%0d diff=%b bo=%b ov=%b want 4 1001 0 0", lat, d, bo, ov);
        end
    endtask

    task automatic test_random();
        logic [3:0] ra, rb, d, ed;
        logic [4:0] f4;
        logic [7:0] sa, sb, d8, ed8;
        logic [8:0] f8;
        logic bo, ov, ebo, eov;
        int lat;
        for (int i = 0; i < 50; i++) begin
            ra = 4'($urandom); rb = 4'($urandom);
            f4 = {1'b0, ra} - {1'b0, rb};
            ed = f4[3:0]; ebo = f4[4];
            eov = (ra[3] != rb[3]) && (ed[3] != ra[3]);
            run4(ra, rb, d, bo, ov, lat);
            total++;
            if (lat !== 4 || d !== ed || bo !== ebo || ov !== eov) begin
                bad++;
                $display("FAIL rand4 a=%b b=%b: lat=%0d diff=%b bo=%b ov=%b want 4 %b %b %b",
                         ra, rb, lat, d, bo, ov, ed, ebo, eov);
            end
        end
        for (int i = 0; i < 50; i++) begin
            sa = 8'($urandom); sb = 8'($urandom);
            f8 = {1'b0, sa} - {1'b0, sb};
            ed8 = f8[7:0]; ebo = f8[8];
            eov = (sa[7] != sb[7]) && (ed8[7] != sa[7]);
            run8(sa, sb, d8, bo, ov, lat);
            total++;
            if (lat !== 8 || d8 !== ed8 || bo !== ebo || ov !== eov) begin
                bad++;
                $display("FAIL rand8 a=%h b=%h: lat=%0d diff=%h bo=%b ov=%b want 8 %h %b %b",
                         sa, sb, lat, d8, bo, ov, ed8, ebo, eov);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_ignore_start();
        test_reset_midop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
